// File: rtl/bp_fe_ras_pkg.sv
// Return-address stack package: checkpoint struct/width macros and per-cycle op decode.
// Optional feature macro: BP_FE_RAS_TOP_REPAIR_EN (checkpoint also carries the top address).

`ifndef BP_FE_RAS_PKG_SV
`define BP_FE_RAS_PKG_SV

`ifdef BP_FE_RAS_TOP_REPAIR_EN
`define BP_FE_RAS_CKPT_WIDTH(vaddr_width_mp, idx_width_mp) \
  ((vaddr_width_mp) + 2*(idx_width_mp) + 1)

`define DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_mp, idx_width_mp) \
  typedef struct packed { \
    logic [(vaddr_width_mp)-1:0] top_addr; \
    logic [(idx_width_mp)-1:0]   tos; \
    logic [(idx_width_mp):0]     count; \
  } bp_fe_ras_ckpt_s
`else
`define BP_FE_RAS_CKPT_WIDTH(vaddr_width_mp, idx_width_mp) \
  (2*(idx_width_mp) + 1)

`define DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_mp, idx_width_mp) \
  typedef struct packed { \
    logic [(idx_width_mp)-1:0]   tos; \
    logic [(idx_width_mp):0]     count; \
  } bp_fe_ras_ckpt_s
`endif

package bp_fe_ras_pkg;

  typedef enum logic [2:0] {
    e_ras_idle      = 3'd0,
    e_ras_clear     = 3'd1,
    e_ras_restore   = 3'd2,
    e_ras_push      = 3'd3,
    e_ras_pop       = 3'd4,
    e_ras_swap      = 3'd5,
    e_ras_underflow = 3'd6
  } bp_fe_ras_op_e;

  // Resolve clear > restore > push/pop; a push on an empty stack wins over a coincident pop.
  function automatic bp_fe_ras_op_e bp_fe_ras_decode(
    input logic clear,
    input logic restore,
    input logic push,
    input logic pop,
    input logic empty
  );
    bp_fe_ras_op_e op;
    op = e_ras_idle;
    if (clear)               op = e_ras_clear;
    else if (restore)        op = e_ras_restore;
    else if (push && pop)    op = empty ? e_ras_push : e_ras_swap;
    else if (push)           op = e_ras_push;
    else if (pop)            op = empty ? e_ras_underflow : e_ras_pop;
    return op;
  endfunction

endpackage

`endif

// File: rtl/bp_fe_ras_mem.sv
// Return-address storage: one synchronous write port, one asynchronous read port, no reset.

module bp_fe_ras_mem
  #(parameter int unsigned els_p = 8
   ,parameter int unsigned width_p = 39
   ,localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
   )
  (input  logic                     clk_i
  ,input  logic                     w_v_i
  ,input  logic [addr_width_lp-1:0] w_addr_i
  ,input  logic [width_p-1:0]       w_data_i
  ,input  logic [addr_width_lp-1:0] r_addr_i
  ,output logic [width_p-1:0]       r_data_o
  );

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_fe_ras.sv
// Frontend return-address stack with circular storage and pointer checkpoint/restore.
// Optional feature macro: BP_FE_RAS_TOP_REPAIR_EN (restore also rewrites the checkpointed top entry).

module bp_fe_ras
  import bp_fe_ras_pkg::*;
  #(parameter int unsigned vaddr_width_p = 39
   ,parameter int unsigned ras_els_p = 8
   ,localparam int unsigned ras_idx_width_p = (ras_els_p > 1) ? $clog2(ras_els_p) : 1
   ,localparam int unsigned ras_ckpt_width_lp = `BP_FE_RAS_CKPT_WIDTH(vaddr_width_p, ras_idx_width_p)
   )
  (input  logic                         clk_i
  ,input  logic                         reset_i
  ,input  logic                         clear_v_i
  ,input  logic                         push_v_i
  ,input  logic [vaddr_width_p-1:0]     push_addr_i
  ,input  logic                         pop_v_i
  ,input  logic                         restore_v_i
  ,input  logic [ras_ckpt_width_lp-1:0] restore_ckpt_i
  ,output logic                         top_v_o
  ,output logic [vaddr_width_p-1:0]     top_addr_o
  ,output logic [ras_ckpt_width_lp-1:0] ckpt_o
  ,output logic                         underflow_o
  );

  `DECLARE_BP_FE_RAS_CKPT_S(vaddr_width_p, ras_idx_width_p);

  localparam logic [ras_idx_width_p:0] full_count_lp = (ras_idx_width_p+1)'(ras_els_p);

  logic [ras_idx_width_p-1:0] tos_r, tos_n;
  logic [ras_idx_width_p:0]   count_r, count_n;
  logic                       empty;
  bp_fe_ras_op_e              op;

  logic                       w_v;
  logic [ras_idx_width_p-1:0] w_addr;
  logic [vaddr_width_p-1:0]   w_data;
  logic [vaddr_width_p-1:0]   r_data;

  bp_fe_ras_ckpt_s ckpt_in, ckpt_cur;

  assign ckpt_in = restore_ckpt_i;
  assign empty   = (count_r == '0);
  assign op      = bp_fe_ras_decode(clear_v_i, restore_v_i, push_v_i, pop_v_i, empty);

  // Next pointer state, write-port select and underflow pulse
  always_comb begin
    tos_n       = tos_r;
    count_n     = count_r;
    w_v         = 1'b0;
    w_addr      = tos_r + ras_idx_width_p'(1);
    w_data      = push_addr_i;
    underflow_o = 1'b0;
    unique case (op)
      e_ras_clear: begin
        tos_n   = '0;
        count_n = '0;
      end
      e_ras_restore: begin
        tos_n   = ckpt_in.tos;
        count_n = ckpt_in.count;
`ifdef BP_FE_RAS_TOP_REPAIR_EN
        if (ckpt_in.count != '0) begin
          w_v    = 1'b1;
          w_addr = ckpt_in.tos;
          w_data = ckpt_in.top_addr;
        end
`endif
      end
      e_ras_push: begin
        tos_n   = tos_r + ras_idx_width_p'(1);
        count_n = (count_r == full_count_lp) ? count_r : count_r + (ras_idx_width_p+1)'(1);
        w_v     = 1'b1;
      end
      e_ras_pop: begin
        tos_n   = tos_r - ras_idx_width_p'(1);
        count_n = count_r - (ras_idx_width_p+1)'(1);
      end
      // Return-then-call replaces the top entry in place
      e_ras_swap: begin
        w_v    = 1'b1;
        w_addr = tos_r;
      end
      e_ras_underflow: begin
        underflow_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tos_r   <= '0;
      count_r <= '0;
    end else begin
      tos_r   <= tos_n;
      count_r <= count_n;
    end
  end

  bp_fe_ras_mem
   #(.els_p   (ras_els_p)
    ,.width_p (vaddr_width_p)
    )
   storage
    (.clk_i    (clk_i)
    ,.w_v_i    (w_v & ~reset_i)
    ,.w_addr_i (w_addr)
    ,.w_data_i (w_data)
    ,.r_addr_i (tos_r)
    ,.r_data_o (r_data)
    );

  assign top_v_o    = ~empty;
  assign top_addr_o = top_v_o ? r_data : '0;

  always_comb begin
    ckpt_cur       = '0;
    ckpt_cur.tos   = tos_r;
    ckpt_cur.count = count_r;
`ifdef BP_FE_RAS_TOP_REPAIR_EN
    ckpt_cur.top_addr = top_addr_o;
`endif
  end

  assign ckpt_o = ckpt_cur;

endmodule

// File: tb/tb_bp_fe_ras.sv
// Directed self-checking bench for bp_fe_ras with a 4-entry stack.

module tb_bp_fe_ras;

  localparam int unsigned VW = 39;
  localparam int unsigned EL = 4;
`ifdef BP_FE_RAS_TOP_REPAIR_EN
  localparam int unsigned CW = VW + 5;
`else
  localparam int unsigned CW = 5;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic          clear_v_i;
  logic          push_v_i;
  logic [VW-1:0] push_addr_i;
  logic          pop_v_i;
  logic          restore_v_i;
  logic [CW-1:0] restore_ckpt_i;
  logic          top_v_o;
  logic [VW-1:0] top_addr_o;
  logic [CW-1:0] ckpt_o;
  logic          underflow_o;
  logic [CW-1:0] saved;

  int errors = 0;
  int checks = 0;

  wire [2:0] obs_count = ckpt_o[2:0];
  wire [1:0] obs_tos   = ckpt_o[4:3];

  bp_fe_ras #(.vaddr_width_p(VW), .ras_els_p(EL)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .clear_v_i      (clear_v_i),
    .push_v_i       (push_v_i),
    .push_addr_i    (push_addr_i),
    .pop_v_i        (pop_v_i),
    .restore_v_i    (restore_v_i),
    .restore_ckpt_i (restore_ckpt_i),
    .top_v_o        (top_v_o),
    .top_addr_o     (top_addr_o),
    .ckpt_o         (ckpt_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic push, input logic [VW-1:0] addr, input logic pop,
                     input logic restore, input logic clear);
    push_v_i    = push;
    push_addr_i = addr;
    pop_v_i     = pop;
    restore_v_i = restore;
    clear_v_i   = clear;
    @(posedge clk); #1;
    push_v_i = 1'b0; pop_v_i = 1'b0; restore_v_i = 1'b0; clear_v_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (top_v_o !== 1'b0) begin errors++; $display("FAIL reset_top_v: got %0h expected 0", top_v_o); end
    checks++; if (top_addr_o !== '0) begin errors++; $display("FAIL reset_top_addr: got %0h expected 0", top_addr_o); end
    checks++; if (ckpt_o !== '0) begin errors++; $display("FAIL reset_ckpt: got %0h expected 0", ckpt_o); end
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %0h expected 0", underflow_o); end
    reset_i = 1'b0;
    #1;
  endtask

  task automatic test_push_pop();
    cyc(1'b1, VW'(39'h1000), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VW'(39'h2000), 1'b0, 1'b0, 1'b0);
    checks++; if (top_addr_o !== VW'(39'h2000)) begin errors++; $display("FAIL push2_top: got %0h expected 2000", top_addr_o); end
    checks++; if (obs_count !== 3'd2) begin errors++; $display("FAIL push2_count: got %0d expected 2", obs_count); end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (top_addr_o !== VW'(39'h1000)) begin errors++; $display("FAIL pop1_top: got %0h expected 1000", top_addr_o); end
    checks++; if (top_v_o !== 1'b1) begin errors++; $display("FAIL pop1_top_v: got %0h expected 1", top_v_o); end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (top_v_o !== 1'b0) begin errors++; $display("FAIL pop2_top_v: got %0h expected 0", top_v_o); end
  endtask

  task automatic test_underflow();
    pop_v_i = 1'b1;
    #1;
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL underflow_pulse: got %0h expected 1", underflow_o); end
    @(posedge clk); #1;
    pop_v_i = 1'b0;
    #1;
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %0h expected 0", underflow_o); end
    checks++; if (obs_count !== 3'd0 || obs_tos !== 2'd0) begin errors++; $display("FAIL underflow_state: got count %0d tos %0d expected 0 0", obs_count, obs_tos); end
    checks++; if (top_addr_o !== '0) begin errors++; $display("FAIL underflow_top: got %0h expected 0", top_addr_o); end
    // push with pop on an empty stack acts as a plain push
    push_v_i = 1'b1; push_addr_i = VW'(39'h44); pop_v_i = 1'b1;
    #1;
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL pushpop_empty_uf: got %0h expected 0", underflow_o); end
    @(posedge clk); #1;
    push_v_i = 1'b0; pop_v_i = 1'b0;
    #1;
    checks++; if (top_addr_o !== VW'(39'h44) || obs_count !== 3'd1) begin errors++; $display("FAIL pushpop_empty: got top %0h count %0d expected 44 1", top_addr_o, obs_count); end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [VW-1:0] exp_top [4];
    exp_top[0] = VW'(39'h50); exp_top[1] = VW'(39'h40);
    exp_top[2] = VW'(39'h30); exp_top[3] = VW'(39'h20);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) cyc(1'b1, VW'(i * 16), 1'b0, 1'b0, 1'b0);
    checks++; if (obs_count !== 3'd4) begin errors++; $display("FAIL overflow_count: got %0d expected 4", obs_count); end
    checks++; if (obs_tos !== 2'd1) begin errors++; $display("FAIL overflow_tos_wrap: got %0d expected 1", obs_tos); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (top_addr_o !== exp_top[i]) begin errors++; $display("FAIL overflow_pop%0d: got %0h expected %0h", i, top_addr_o, exp_top[i]); end
      if (i == 2) begin
        checks++; if (obs_tos !== 2'd3) begin errors++; $display("FAIL underflow_tos_wrap: got %0d expected 3", obs_tos); end
      end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (top_v_o !== 1'b0) begin errors++; $display("FAIL overflow_drained: got %0h expected 0", top_v_o); end
  endtask

  task automatic test_push_pop_same();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, VW'(39'h100), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VW'(39'h200), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VW'(39'h300), 1'b1, 1'b0, 1'b0);
    checks++; if (top_addr_o !== VW'(39'h300)) begin errors++; $display("FAIL swap_top: got %0h expected 300", top_addr_o); end
    checks++; if (obs_count !== 3'd2) begin errors++; $display("FAIL swap_count: got %0d expected 2", obs_count); end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (top_addr_o !== VW'(39'h100)) begin errors++; $display("FAIL swap_pop: got %0h expected 100", top_addr_o); end
  endtask

  task automatic test_restore();
    logic [VW-1:0] exp_top;
`ifdef BP_FE_RAS_TOP_REPAIR_EN
    exp_top = VW'(39'h200);
`else
    exp_top = VW'(39'hB);
`endif
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, VW'(39'h100), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VW'(39'h200), 1'b0, 1'b0, 1'b0);
    saved = ckpt_o;
    cyc(1'b1, VW'(39'hA), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, VW'(39'hB), 1'b0, 1'b0, 1'b0);
    restore_ckpt_i = saved;
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (top_addr_o !== exp_top) begin errors++; $display("FAIL restore_top: got %0h expected %0h", top_addr_o, exp_top); end
    checks++; if (obs_count !== 3'd2 || obs_tos !== 2'd2) begin errors++; $display("FAIL restore_ptrs: got count %0d tos %0d expected 2 2", obs_count, obs_tos); end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (top_addr_o !== VW'(39'h100)) begin errors++; $display("FAIL restore_pop: got %0h expected 100", top_addr_o); end
  endtask

  task automatic test_priority();
    logic [VW-1:0] exp_top;
`ifdef BP_FE_RAS_TOP_REPAIR_EN
    exp_top = VW'(39'h200);
`else
    exp_top = VW'(39'hB);
`endif
    restore_ckpt_i = saved;
    cyc(1'b1, VW'(39'h999), 1'b0, 1'b1, 1'b1);
    checks++; if (obs_count !== 3'd0 || top_v_o !== 1'b0) begin errors++; $display("FAIL clear_priority: got count %0d top_v %0h expected 0 0", obs_count, top_v_o); end
    cyc(1'b1, VW'(39'h777), 1'b0, 1'b1, 1'b0);
    checks++; if (obs_count !== 3'd2 || obs_tos !== 2'd2) begin errors++; $display("FAIL restore_priority: got count %0d tos %0d expected 2 2", obs_count, obs_tos); end
    checks++; if (top_addr_o !== exp_top) begin errors++; $display("FAIL restore_push_ignored: got %0h expected %0h", top_addr_o, exp_top); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, VW'(39'h55), 1'b0, 1'b0, 1'b0);
    reset_i = 1'b1;
    cyc(1'b1, VW'(39'h66), 1'b0, 1'b0, 1'b0);
    reset_i = 1'b0;
    checks++; if (top_v_o !== 1'b0 || top_addr_o !== '0) begin errors++; $display("FAIL midreset_top: got v %0h addr %0h expected 0 0", top_v_o, top_addr_o); end
    checks++; if (ckpt_o !== '0) begin errors++; $display("FAIL midreset_ckpt: got %0h expected 0", ckpt_o); end
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL midreset_underflow: got %0h expected 0", underflow_o); end
  endtask

  initial begin
    reset_i = 1'b1; clear_v_i = 1'b0; push_v_i = 1'b0; pop_v_i = 1'b0;
    restore_v_i = 1'b0; push_addr_i = '0; restore_ckpt_i = '0; saved = '0;
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_push_pop_same();
    test_restore();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
